div_mse_accumulator: RTL and testbench
======================================

DIV_MSE_ACCUMULATOR -- requirements
Module: div_mse_accumulator

Interface
REQ-001 SHALL have parameter W, default 8, meaning quotient/remainder width; matches the 16/8 array divider output.
REQ-002 SHALL have parameter CNT_W, default 16, meaning sample-counter width; up to 2^CNT_W samples per run.
REQ-003 SHALL have parameter ACC_W, default 2*W+CNT_W, meaning accumulator width; overflow-free by construction.
REQ-004 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run; accepted only in IDLE or DONE.
- num_samples  in  CNT_W  samples in the run, sampled at start; 0 means 2^CNT_W.
- in_valid  in  1  sample pair present.
- in_ready  out  1  block accepts a sample this cycle.
- q_apx, r_apx  in  W each  approximate divider quotient/remainder.
- q_ref, r_ref  in  W each  exact divider quotient/remainder.
- sse_q, sse_r  out  ACC_W each  sum of squared errors.
- max_err_q  out  W  largest |q_apx-q_ref| seen.
- err_cnt  out  CNT_W  samples with any q or r mismatch.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; results stable.

Function
REQ-005 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: go to RUN; clear all results; load remaining = num_samples.
- RUN: exit to DRAIN when the last sample is accepted.
- DRAIN: exit to DONE when the pipeline is empty.
- DONE: hold until the next start.
REQ-006 in_ready SHALL be 1 only in RUN; a sample SHALL be accepted when in_valid && in_ready.
REQ-007 Datapath SHALL be a 3-stage pipeline: S1 registers absolute differences; S2 registers squares (2W bits); S3 adds into sse_q/sse_r, updates max_err_q and err_cnt.
REQ-008 Absolute differences SHALL be unsigned |a-b|, W bits, computed without wraparound (e.g. 0 vs 255 gives 255).
REQ-009 Each pipeline stage SHALL carry a valid bit; bubbles (in_valid=0) SHALL leave the accumulators unchanged.
REQ-010 DRAIN SHALL last exactly 3 cycles after the last accept; done SHALL assert on the 4th cycle after the final accept edge.
REQ-011 start during RUN or DRAIN SHALL be ignored.
REQ-012 start and in_valid in the same IDLE/DONE cycle SHALL NOT accept the sample (in_ready=0 that cycle).
REQ-013 err_cnt SHALL increment when q_apx!=q_ref or r_apx!=r_ref, once per sample.
REQ-014 Accumulators SHALL NOT saturate or wrap for any legal run; ACC_W guarantees this.
REQ-015 Outputs SHALL be registered; sse_*, max_err_q and err_cnt SHALL be readable at all times, updating live in RUN/DRAIN.

Reset
REQ-016 rst SHALL force IDLE, clear all pipeline valids, and zero all outputs. Exception: in_ready, busy and done are forced 0.
REQ-017 rst mid-run SHALL discard in-flight samples with no partial accumulation on the following cycle.

Structure
REQ-018 A shared package SHALL hold the FSM state enum and the W/CNT_W/ACC_W defaults.
REQ-019 One sub-module, err_sq_stage, SHALL compute abs-difference and square for one operand pair; it SHALL be instantiated twice (q and r).

Verification
REQ-020 Exact-match run: num_samples=4, all pairs equal. Required: done after last accept +4 cycles; sse_q=sse_r=0; err_cnt=0; max_err_q=0.
REQ-021 Single error: q_apx=10, q_ref=7, r equal, N=1. Required: sse_q=9, sse_r=0, max_err_q=3, err_cnt=1.
REQ-022 Extreme values: q_apx=0, q_ref=255, r_apx=255, r_ref=0, N=2. Required: sse_q=sse_r=130050, max_err_q=255, err_cnt=2.
REQ-023 Bubbles and backpressure: N=3 with in_valid toggling 1,0,1,0,1, plus a start pulse mid-run. Required: start ignored; exactly 3 samples accumulated; in_ready=0 in DRAIN.
REQ-024 Reset mid-run: rst asserted 1 cycle after the 2nd accept. Required: next cycle all outputs 0 and state IDLE; a fresh run of N=1 then gives correct results.
REQ-025 num_samples=0 with a small CNT_W=4 build. Required: exactly 16 samples accepted before DRAIN.

Source files
------------

// File: rtl/div_mse_accumulator_pkg.sv
// Shared definitions for the divider MSE accumulator: width defaults and FSM states.
package div_mse_accumulator_pkg;

   localparam int DEF_W     = 8;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/div_mse_accumulator_if.sv
// Sample/result bundle between a stimulus source (master) and the accumulator (slave).
interface div_mse_accumulator_if
   import div_mse_accumulator_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int ACC_W = 2*W + CNT_W
);

   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     q_apx;
   logic [W-1:0]     r_apx;
   logic [W-1:0]     q_ref;
   logic [W-1:0]     r_ref;
   logic [ACC_W-1:0] sse_q;
   logic [ACC_W-1:0] sse_r;
   logic [W-1:0]     max_err_q;
   logic [CNT_W-1:0] err_cnt;
   logic             busy;
   logic             done;

   modport master (
      output start, num_samples, in_valid, q_apx, r_apx, q_ref, r_ref,
      input  in_ready, sse_q, sse_r, max_err_q, err_cnt, busy, done
   );

   modport slave (
      input  start, num_samples, in_valid, q_apx, r_apx, q_ref, r_ref,
      output in_ready, sse_q, sse_r, max_err_q, err_cnt, busy, done
   );

endinterface

// File: rtl/err_sq_stage.sv
// Two pipeline stages for one operand pair: S1 registers |a-b|, S2 registers its square
// (the difference is carried alongside so the parent can track max error and mismatches).
module err_sq_stage
   import div_mse_accumulator_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           i_en_s1,
   input  logic           i_en_s2,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [W-1:0]   o_abs,
   output logic [2*W-1:0] o_sq
);

   logic [W-1:0]   w_abs;
   logic [W-1:0]   r_abs_s1;
   logic [W-1:0]   r_abs_s2;
   logic [2*W-1:0] r_sq_s2;

   // Subtract the smaller from the larger so the result never wraps.
   assign w_abs = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);

   // NOTE: data registers carry no reset; the parent's valid bits decide when they mean
   // anything, so resetting them would only add reset fan-out.
   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (i_en_s1) begin
         r_abs_s1 <= w_abs;
      end
      if (i_en_s2) begin
         r_abs_s2 <= r_abs_s1;
         r_sq_s2  <= {{W{1'b0}}, r_abs_s1} * {{W{1'b0}}, r_abs_s1};
      end
   end

   assign o_abs = r_abs_s2;
   assign o_sq  = r_sq_s2;

endmodule

// File: rtl/div_mse_accumulator.sv
// Accumulates squared quotient/remainder errors of an approximate divider against an exact
// one over a run of samples, through a 3-stage valid-tagged pipeline.
module div_mse_accumulator
   import div_mse_accumulator_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int ACC_W = 2*W + CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   div_mse_accumulator_if.slave bus
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_DRAIN = ST_DRAIN;
   localparam logic [1:0] S_DONE  = ST_DONE;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [1:0]       r_drain_cnt;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_v1;
   logic             r_v2;
   logic [ACC_W-1:0] r_sse_q;
   logic [ACC_W-1:0] r_sse_r;
   logic [W-1:0]     r_max_err_q;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_start;
   logic             w_drain_end;
   logic [W-1:0]     w_abs_q;
   logic [W-1:0]     w_abs_r;
   logic [2*W-1:0]   w_sq_q;
   logic [2*W-1:0]   w_sq_r;

   assign w_accept    = bus.in_valid && r_in_ready;
   // A loaded count of 0 decrements through all-ones, giving 2^CNT_W samples for free.
   assign w_last      = w_accept && (r_remaining == CNT_W'(1));
   assign w_start     = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == 2'd2);

   err_sq_stage #(.W(W)) u_q_stage (
      .clk     (clk),
      .i_en_s1 (w_accept),
      .i_en_s2 (r_v1),
      .i_a     (bus.q_apx),
      .i_b     (bus.q_ref),
      .o_abs   (w_abs_q),
      .o_sq    (w_sq_q)
   );

   err_sq_stage #(.W(W)) u_r_stage (
      .clk     (clk),
      .i_en_s1 (w_accept),
      .i_en_s2 (r_v1),
      .i_a     (bus.r_apx),
      .i_b     (bus.r_ref),
      .o_abs   (w_abs_r),
      .o_sq    (w_sq_r)
   );

   // NOTE: the default assignment first keeps this combinational block free of latches.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (w_start)     w_state_nxt = S_RUN;
         S_RUN:          if (w_last)      w_state_nxt = S_DRAIN;
         S_DRAIN:        if (w_drain_end) w_state_nxt = S_DONE;
         default:                         w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_drain_cnt <= '0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_sse_q     <= '0;
         r_sse_r     <= '0;
         r_max_err_q <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == S_RUN);
         r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
         r_done      <= (w_state_nxt == S_DONE);
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
         r_v1        <= w_accept;
         r_v2        <= r_v1;

         if (w_start) begin
            r_remaining <= bus.num_samples;
         end else if (w_accept) begin
            r_remaining <= r_remaining - CNT_W'(1);
         end

         // The pipeline is empty whenever start is honoured, so clearing cannot drop a sample.
         if (w_start) begin
            r_sse_q     <= '0;
            r_sse_r     <= '0;
            r_max_err_q <= '0;
            r_err_cnt   <= '0;
         end else if (r_v2) begin
            r_sse_q <= r_sse_q + ACC_W'(w_sq_q);
            r_sse_r <= r_sse_r + ACC_W'(w_sq_r);
            if (w_abs_q > r_max_err_q) begin
               r_max_err_q <= w_abs_q;
            end
            if ((w_abs_q != '0) || (w_abs_r != '0)) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.sse_q     = r_sse_q;
   assign bus.sse_r     = r_sse_r;
   assign bus.max_err_q = r_max_err_q;
   assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_div_mse_accumulator.sv
// Randomized bench for div_mse_accumulator: a default build and a CNT_W=4 build, both checked
// against a plain-arithmetic error model.
module tb_div_mse_accumulator;
   import div_mse_accumulator_pkg::*;

   localparam int W      = 8;
   localparam int CNT_W  = 16;
   localparam int ACC_W  = 2*W + CNT_W;
   localparam int CNT_W4 = 4;
   localparam int ACC_W4 = 2*W + CNT_W4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   longint m_sse_q;
   longint m_sse_r;
   int     m_max;
   int     m_err;

   always #5 clk = ~clk;

   div_mse_accumulator_if #(.W(W), .CNT_W(CNT_W),  .ACC_W(ACC_W))  bus  ();
   div_mse_accumulator_if #(.W(W), .CNT_W(CNT_W4), .ACC_W(ACC_W4)) bus4 ();

   div_mse_accumulator #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   div_mse_accumulator #(.W(W), .CNT_W(CNT_W4), .ACC_W(ACC_W4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic m_clear();
      m_sse_q = 0;
      m_sse_r = 0;
      m_max   = 0;
      m_err   = 0;
   endtask

   task automatic m_add(input int qa, input int qr, input int ra, input int rr);
      int dq;
      int dr;
      dq = (qa > qr) ? qa - qr : qr - qa;
      dr = (ra > rr) ? ra - rr : rr - ra;
      m_sse_q += longint'(dq * dq);
      m_sse_r += longint'(dr * dr);
      if (dq > m_max) m_max = dq;
      if (qa != qr || ra != rr) m_err++;
   endtask

   // 0: exact, 1: single q error 10 vs 7, 2: extremes, 3: fully random, else: sparse errors
   task automatic gen(input int mode, output logic [W-1:0] qa, output logic [W-1:0] ra,
                      output logic [W-1:0] qr, output logic [W-1:0] rr);
      qr = W'($urandom);
      rr = W'($urandom);
      case (mode)
         0: begin qa = qr; ra = rr; end
         1: begin qa = 8'd10; qr = 8'd7; ra = rr; end
         2: begin qa = 8'd0; qr = 8'd255; ra = 8'd255; rr = 8'd0; end
         3: begin qa = W'($urandom); ra = W'($urandom); end
         default: begin
            qa = ($urandom_range(3) == 0) ? W'($urandom) : qr;
            ra = ($urandom_range(3) == 0) ? W'($urandom) : rr;
         end
      endcase
   endtask

   // bub: 0 always valid, 1 toggling 1,0,1,..., 2 random ~70% valid
   task automatic run_check(input string tag, input int n, input int mode, input int bub,
                            input bit mid_start);
      int acc;
      int cyc;
      logic v;
      logic [W-1:0] qa, ra, qr, rr;
      m_clear();
      @(negedge clk);
      // A sample offered together with start must be refused.
      bus.start       = 1'b1;
      bus.num_samples = CNT_W'(n);
      bus.in_valid    = 1'b1;
      bus.q_apx = 8'd200; bus.q_ref = 8'd1; bus.r_apx = 8'd3; bus.r_ref = 8'd99;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, ".clr_sse_q"}, 64'(bus.sse_q), 64'd0);
      check({tag, ".clr_err"},   64'(bus.err_cnt), 64'd0);
      check({tag, ".busy_run"},  64'(bus.busy), 64'd1);
      acc = 0;
      cyc = 0;
      while (acc < n && cyc < 8*n + 20) begin
         check({tag, ".ready_run"}, 64'(bus.in_ready), 64'd1);
         case (bub)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(9) < 7);
         endcase
         gen(mode, qa, ra, qr, rr);
         bus.in_valid = v;
         bus.q_apx = qa; bus.r_apx = ra; bus.q_ref = qr; bus.r_ref = rr;
         if (mid_start && cyc == 1) bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         if (v) begin
            acc++;
            m_add(int'(qa), int'(qr), int'(ra), int'(rr));
         end
         cyc++;
      end
      check({tag, ".accepts"}, 64'(acc), 64'(n));
      // Keep offering data through DRAIN; none of it may be taken.
      bus.in_valid = 1'b1;
      if (mid_start) bus.start = 1'b1;
      check({tag, ".ready_drain"}, 64'(bus.in_ready), 64'd0);
      check({tag, ".busy_drain"},  64'(bus.busy), 64'd1);
      check({tag, ".done_e0"},     64'(bus.done), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, ".ready_drain2"}, 64'(bus.in_ready), 64'd0);
      check({tag, ".done_e1"},      64'(bus.done), 64'd0);
      @(negedge clk);
      check({tag, ".done_e2"}, 64'(bus.done), 64'd0);
      @(negedge clk);
      check({tag, ".done_e3"}, 64'(bus.done), 64'd1);
      check({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
      check({tag, ".sse_q"}, 64'(bus.sse_q), 64'(m_sse_q));
      check({tag, ".sse_r"}, 64'(bus.sse_r), 64'(m_sse_r));
      check({tag, ".max_err_q"}, 64'(bus.max_err_q), 64'(m_max));
      check({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'(m_err));
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, ".done_hold"}, 64'(bus.done), 64'd1);
      check({tag, ".sse_q_hold"}, 64'(bus.sse_q), 64'(m_sse_q));
   endtask

   task automatic reset_mid_run();
      @(negedge clk);
      bus.start       = 1'b1;
      bus.num_samples = CNT_W'(8);
      bus.in_valid    = 1'b0;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.q_apx = 8'd0; bus.q_ref = 8'd255; bus.r_apx = 8'd255; bus.r_ref = 8'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst.sse_q",     64'(bus.sse_q), 64'd0);
      check("rst.sse_r",     64'(bus.sse_r), 64'd0);
      check("rst.max_err_q", 64'(bus.max_err_q), 64'd0);
      check("rst.err_cnt",   64'(bus.err_cnt), 64'd0);
      check("rst.in_ready",  64'(bus.in_ready), 64'd0);
      check("rst.busy",      64'(bus.busy), 64'd0);
      check("rst.done",      64'(bus.done), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst.after_sse_q", 64'(bus.sse_q), 64'd0);
         check("rst.after_err",   64'(bus.err_cnt), 64'd0);
         check("rst.idle_ready",  64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_full_cnt4();
      int acc;
      logic [W-1:0] qa, ra, qr, rr;
      m_clear();
      @(negedge clk);
      bus4.start       = 1'b1;
      bus4.num_samples = '0;
      bus4.in_valid    = 1'b0;
      @(negedge clk);
      bus4.start = 1'b0;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus4.in_ready) begin
            gen(3, qa, ra, qr, rr);
            bus4.q_apx = qa; bus4.r_apx = ra; bus4.q_ref = qr; bus4.r_ref = rr;
            bus4.in_valid = 1'b1;
            m_add(int'(qa), int'(qr), int'(ra), int'(rr));
            acc++;
         end else begin
            bus4.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("cnt4.accepts",   64'(acc), 64'd16);
      check("cnt4.done",      64'(bus4.done), 64'd1);
      check("cnt4.sse_q",     64'(bus4.sse_q), 64'(m_sse_q));
      check("cnt4.sse_r",     64'(bus4.sse_r), 64'(m_sse_r));
      check("cnt4.max_err_q", 64'(bus4.max_err_q), 64'(m_max));
      check("cnt4.err_cnt",   64'(bus4.err_cnt), 64'(m_err % 16));
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.num_samples = '0; bus.in_valid = 1'b0;
      bus.q_apx = '0; bus.r_apx = '0; bus.q_ref = '0; bus.r_ref = '0;
      bus4.start = 1'b0; bus4.num_samples = '0; bus4.in_valid = 1'b0;
      bus4.q_apx = '0; bus4.r_apx = '0; bus4.q_ref = '0; bus4.r_ref = '0;
      repeat (3) @(negedge clk);
      check("reset.sse_q",     64'(bus.sse_q), 64'd0);
      check("reset.sse_r",     64'(bus.sse_r), 64'd0);
      check("reset.max_err_q", 64'(bus.max_err_q), 64'd0);
      check("reset.err_cnt",   64'(bus.err_cnt), 64'd0);
      check("reset.in_ready",  64'(bus.in_ready), 64'd0);
      check("reset.busy",      64'(bus.busy), 64'd0);
      check("reset.done",      64'(bus.done), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_check("exact",   4, 0, 0, 1'b0);
      run_check("single",  1, 1, 0, 1'b0);
      run_check("extreme", 2, 2, 0, 1'b0);
      run_check("bubble",  3, 3, 1, 1'b1);
      reset_mid_run();
      run_check("rst_fresh", 1, 3, 0, 1'b0);
      run_full_cnt4();
      for (int i = 0; i < 6; i++) begin
         run_check("rand", int'($urandom_range(20, 1)), (i % 2 == 0) ? 3 : 4, 2, (i % 2) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
